// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the IF-stage fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, next-pc source select, reset/exception addresses, NOP encoding.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_SQUASH = 2'd3
  } fetch_state_t;

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_SEQ  = 3'd1,
    SEL_TGT  = 3'd2,
    SEL_EXC  = 3'd3,
    SEL_EPC  = 3'd4
  } pc_sel_t;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC   = 32'h0000_4180;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_sel.sv
// Purpose: priority mux choosing the next fetch address and the IF/ID strobes.
// Latency: purely combinational, zero cycles.
// Backpressure: stall holds the pc and drops if_id_en unless an exception or eret overrides it.
// Ports: state/pc/pc4/pend_squash from the fetch FSM; pipeline requests in;
//        sel, next_pc, if_id_en, if_id_flush, fetch_valid, squash_take, pend_next out.
module fetch_pc_sel
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_TARGET = 32'h0000_4180
) (
  input  fetch_state_t state,
  input  logic [31:0]  pc,
  input  logic [31:0]  pc4,
  input  logic         pend_squash,
  input  logic         stall,
  input  logic         redir_valid,
  input  logic [31:0]  redir_target,
  input  logic         add_nop,
  input  logic         exc_req,
  input  logic         eret,
  input  logic [31:0]  epc,
  output pc_sel_t      sel,
  output logic [31:0]  next_pc,
  output logic         if_id_en,
  output logic         if_id_flush,
  output logic         fetch_valid,
  output logic         squash_take,
  output logic         pend_next
);

  always_comb begin
    sel         = SEL_HOLD;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    squash_take = 1'b0;
    pend_next   = pend_squash;
    if (state == ST_BOOT) begin
      // IF/ID holds a nop while the first fetch is issued; pc is not advanced.
      if_id_flush = 1'b1;
      pend_next   = 1'b0;
    end else if (exc_req) begin
      sel         = SEL_EXC;
      if_id_en    = 1'b1;
      if_id_flush = 1'b1;
      pend_next   = 1'b0;
    end else if (eret) begin
      // A pending squash belongs to the stream being abandoned, so drop it.
      sel         = SEL_EPC;
      if_id_en    = 1'b1;
      if_id_flush = 1'b1;
      pend_next   = 1'b0;
    end else if (stall) begin
      // Remember a squash request seen under stall so release still nullifies the slot.
      if (redir_valid && add_nop) pend_next = 1'b1;
    end else if (redir_valid) begin
      sel      = SEL_TGT;
      if_id_en = 1'b1;
      if (add_nop || pend_squash) begin
        if_id_flush = 1'b1;
        squash_take = 1'b1;
        pend_next   = 1'b0;
      end
    end else begin
      sel      = SEL_SEQ;
      if_id_en = 1'b1;
      if (pend_squash) begin
        if_id_flush = 1'b1;
        pend_next   = 1'b0;
      end
    end
  end

  assign fetch_valid = (state != ST_BOOT) && !if_id_flush;

  always_comb begin
    next_pc = pc;
    case (sel)
      SEL_SEQ: next_pc = pc4;
      SEL_TGT: next_pc = redir_target;
      SEL_EXC: next_pc = EXC_TARGET;
      SEL_EPC: next_pc = epc;
      default: next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Purpose: IF-stage program counter sequencer with delay-slot squash and exception redirect.
// Latency: pc registered (one cycle to update); pc4 and IF/ID strobes combinational.
// Backpressure: stall freezes pc and IF/ID; exc_req/eret override stall.
// Ports: clk, reset (async active-high); stall, redir_valid/redir_target/add_nop,
//        exc_req, eret/epc in; pc, pc4, if_id_en, if_id_flush, fetch_valid, state_o out.
// Optional: FETCH_ADEL_EN adds a registered adel_if fetch address-error flag.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
`ifdef FETCH_ADEL_EN
  ,
  parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI  = 32'h0000_6ffc
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  input  logic        add_nop,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        fetch_valid,
  output logic [1:0]  state_o
`ifdef FETCH_ADEL_EN
  ,
  output logic        adel_if
`endif
);
  import fetch_pkg::*;

  fetch_state_t state, state_nxt;
  pc_sel_t      sel;
  logic [31:0]  next_pc;
  logic         pend_squash, pend_next, squash_take;

  assign pc4     = pc + 32'd4;
  assign state_o = state;

  fetch_pc_sel #(
    .EXC_TARGET (EXC_VEC)
  ) u_pc_sel (
    .state        (state),
    .pc           (pc),
    .pc4          (pc4),
    .pend_squash  (pend_squash),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .add_nop      (add_nop),
    .exc_req      (exc_req),
    .eret         (eret),
    .epc          (epc),
    .sel          (sel),
    .next_pc      (next_pc),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .fetch_valid  (fetch_valid),
    .squash_take  (squash_take),
    .pend_next    (pend_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      pend_squash <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= next_pc;
      pend_squash <= pend_next;
    end
  end

  // SEL_HOLD outside BOOT only arises from stall; a squashing redirect marks the slot.
  always_comb begin
    state_nxt = ST_RUN;
    if (state == ST_BOOT)       state_nxt = ST_RUN;
    else if (sel == SEL_HOLD)   state_nxt = ST_HOLD;
    else if (squash_take)       state_nxt = ST_SQUASH;
    else                        state_nxt = ST_RUN;
  end

`ifdef FETCH_ADEL_EN
  logic adel_next;
  assign adel_next = (next_pc[1:0] != 2'b00) || (next_pc < IMEM_LO) || (next_pc > IMEM_HI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) adel_if <= 1'b0;
    else       adel_if <= adel_next;
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Purpose: self-checking bench for fetch_ctrl against a behavioural fetch model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redir_valid, add_nop, exc_req, eret;
  logic [31:0] redir_target, epc;
  logic [31:0] pc, pc4;
  logic        if_id_en, if_id_flush, fetch_valid;
  logic [1:0]  state_o;
`ifdef FETCH_ADEL_EN
  logic        adel_if;
`endif

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .add_nop      (add_nop),
    .exc_req      (exc_req),
    .eret         (eret),
    .epc          (epc),
    .pc           (pc),
    .pc4          (pc4),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .fetch_valid  (fetch_valid),
    .state_o      (state_o)
`ifdef FETCH_ADEL_EN
    ,
    .adel_if      (adel_if)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int flush_seen = 0;

  // Reference model: architectural fetch address plus a few flags describing
  // what the previous cycle did (booting, stalled, squashed slot, pending squash).
  logic [31:0] m_pc, m_npc;
  bit          m_boot, m_hold, m_squash, m_pend, m_adel;
  bit          n_hold, n_squash, n_pend;
  bit          exp_en, exp_flush, exp_fv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_state();
    if (m_boot)   return 32'd0;
    if (m_hold)   return 32'd2;
    if (m_squash) return 32'd3;
    return 32'd1;
  endfunction

  task automatic model_eval();
    n_hold = 0; n_squash = 0; n_pend = m_pend;
    exp_en = 1; exp_flush = 0; m_npc = m_pc;
    if (m_boot) begin
      exp_en = 0; exp_flush = 1; n_pend = 0;
    end else if (exc_req) begin
      m_npc = EXC_PC; exp_flush = 1; n_pend = 0;
    end else if (eret) begin
      m_npc = epc; exp_flush = 1; n_pend = 0;
    end else if (stall) begin
      exp_en = 0; n_hold = 1;
      if (redir_valid && add_nop) n_pend = 1;
    end else if (redir_valid) begin
      m_npc = redir_target;
      if (add_nop || m_pend) begin exp_flush = 1; n_pend = 0; n_squash = 1; end
    end else begin
      m_npc = m_pc + 32'd4;
      if (m_pend) begin exp_flush = 1; n_pend = 0; end
    end
    exp_fv = !m_boot && !exp_flush;
  endtask

  task automatic cycle(input bit st, input bit rv, input logic [31:0] tgt, input bit an,
                       input bit ex, input bit er, input logic [31:0] ep);
    stall = st; redir_valid = rv; redir_target = tgt; add_nop = an;
    exc_req = ex; eret = er; epc = ep;
    #1;
    model_eval();
    check("if_id_en", if_id_en, exp_en);
    check("if_id_flush", if_id_flush, exp_flush);
    check("fetch_valid", fetch_valid, exp_fv);
    check("pc4", pc4, m_pc + 32'd4);
    if (if_id_flush) flush_seen++;
    @(posedge clk);
    m_pc = m_npc; m_boot = 0; m_hold = n_hold; m_squash = n_squash; m_pend = n_pend;
    m_adel = (m_pc[1:0] != 2'b00) || (m_pc < 32'h0000_3000) || (m_pc > 32'h0000_6ffc);
    #1;
    check("pc", pc, m_pc);
    check("state", state_o, exp_state());
`ifdef FETCH_ADEL_EN
    check("adel_if", adel_if, m_adel);
`endif
  endtask

  task automatic idle();
    cycle(0, 0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_pc = RST_PC; m_boot = 1; m_hold = 0; m_squash = 0; m_pend = 0; m_adel = 0;
    check("rst_pc", pc, RST_PC);
    check("rst_state", state_o, 32'd0);
    check("rst_if_id_en", if_id_en, 32'd0);
    check("rst_if_id_flush", if_id_flush, 32'd1);
    check("rst_fetch_valid", fetch_valid, 32'd0);
`ifdef FETCH_ADEL_EN
    check("rst_adel_if", adel_if, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    int k;
    k = $urandom_range(0, 19);
    a = {16'h0000, 16'($urandom_range(32'h3000, 32'h6ffc))};
    if (k == 0)      a = 32'hffff_fffc;
    else if (k == 1) a = a | 32'h2;
    else             a = a & ~32'h3;
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; stall = 0; redir_valid = 0; redir_target = 0; add_nop = 0;
    exc_req = 0; eret = 0; epc = 0;
    do_reset();

    // Boot then sequential fetch.
    idle(); check("boot_pc", pc, 32'h3000);
    idle(); check("seq_pc1", pc, 32'h3004);
    idle(); check("seq_pc2", pc, 32'h3008);
    idle(); idle(); check("seq_pc4", pc, 32'h3010);

    // Plain redirect, then squashing redirect.
    cycle(0, 1, 32'h3040, 0, 0, 0, 0);
    check("redir_pc", pc, 32'h3040);
    cycle(0, 1, 32'h3040, 1, 0, 0, 0);
    check("squash_pc", pc, 32'h3040);
    check("squash_state", state_o, 32'd3);

    // Stall with a held squashing redirect: exactly one flush on release.
    flush_seen = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 32'h3080, 1, 0, 0, 0);
      check("stall_pc", pc, 32'h3040);
    end
    cycle(0, 1, 32'h3080, 1, 0, 0, 0);
    check("release_pc", pc, 32'h3080);
    check("release_flush_count", flush_seen, 32'd1);

    // Exception during stall, then eret.
    cycle(0, 1, 32'h3100, 0, 0, 0, 0);
    cycle(1, 0, 32'h0, 0, 1, 0, 0);
    check("exc_pc", pc, EXC_PC);
    cycle(0, 0, 32'h0, 0, 0, 1, 32'h3104);
    check("eret_pc", pc, 32'h3104);

    // Wrap-around and exc/eret collision.
    cycle(0, 1, 32'hffff_fffc, 0, 0, 0, 0);
    idle(); check("wrap_pc", pc, 32'h0);
    cycle(0, 0, 32'h0, 0, 1, 1, 32'h3200);
    check("exc_over_eret", pc, EXC_PC);

    // Reset while squashing.
    cycle(0, 1, 32'h3200, 1, 0, 0, 0);
    do_reset();
    idle();

`ifdef FETCH_ADEL_EN
    cycle(0, 1, 32'h3002, 0, 0, 0, 0);
    check("adel_misaligned", adel_if, 32'd1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, pick_addr(),
              $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0,
              $urandom_range(0, 24) == 0, pick_addr());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
